// File: rtl/selftrigger_baseline_holdoff_filter.sv
// Single-channel self-trigger front end: frozen-on-pulse exponential baseline,
// baseline subtraction, power-of-two moving mean and an armed/holdoff trigger FSM.
module selftrigger_baseline_holdoff_filter #(
    parameter int DATA_W            = 16,
    parameter int THR_W             = 14,
    parameter int LPF_SHIFT         = 6,
    parameter int WIN_LOG2          = 5,
    parameter int HOLDOFF           = 64,
    parameter int HYST              = 16,
    parameter int DEFAULT_THRESHOLD = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [THR_W-1:0]  threshold_value,
    input  logic [1:0]               output_selector,
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] baseline,
    output logic signed [DATA_W-1:0] y,
    output logic                     trigger_output,
    output logic                     triggered,
    output logic [15:0]              trigger_count,
    output logic [1:0]               fsm_state
);

    localparam int ACC_W  = DATA_W + LPF_SHIFT;
    localparam int SUM_W  = DATA_W + WIN_LOG2;
    localparam int WIN    = 1 << WIN_LOG2;
    localparam int HC_W   = $clog2(HOLDOFF + 1);
    localparam int FILL_W = WIN_LOG2 + 1;
    localparam int EXT_W  = DATA_W + 2;

    localparam logic signed [EXT_W-1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W:0]  HYST_V  = (DATA_W+1)'(HYST);
    localparam logic [HC_W-1:0]         HOLD_V  = HC_W'(HOLDOFF);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        TRIGGERED = 2'd2,
        HOLD      = 2'd3
    } state_t;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [EXT_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    // registers
    logic signed [THR_W-1:0]  thr_q, thr_d;
    logic                     seeded_q, seeded_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] d_r_q, d_r_d;
    logic signed [DATA_W-1:0] dl_q [WIN];
    logic signed [DATA_W-1:0] dl_d [WIN];
    logic [WIN_LOG2-1:0]      wp_q, wp_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    state_t                   state_q, state_d;
    logic [HC_W-1:0]          hcnt_q, hcnt_d;
    logic                     trig_q, trig_d;
    logic [15:0]              cnt_q, cnt_d;

    // combinational helpers
    logic signed [DATA_W-1:0] mm;
    logic signed [EXT_W-1:0]  x_ext, bl_ext, dr_ext, mm_ext;
    logic signed [ACC_W-1:0]  acc_step;
    logic signed [DATA_W:0]   mm_cmp, thr_cmp, thr_lo;
    logic                     frozen;
    logic                     above_thr, above_lo;

    // Acc and sum are sized so the arithmetic shift plus truncation is a plain slice.
    assign baseline = acc_q[LPF_SHIFT +: DATA_W];
    assign mm       = sum_q[WIN_LOG2 +: DATA_W];

    assign x_ext  = {{2{x[DATA_W-1]}}, x};
    assign bl_ext = {{2{baseline[DATA_W-1]}}, baseline};
    assign dr_ext = {{2{d_r_q[DATA_W-1]}}, d_r_q};
    assign mm_ext = {{2{mm[DATA_W-1]}}, mm};

    assign acc_step = acc_q + {{LPF_SHIFT{x[DATA_W-1]}}, x}
                            - {{LPF_SHIFT{baseline[DATA_W-1]}}, baseline};

    assign mm_cmp    = {mm[DATA_W-1], mm};
    assign thr_cmp   = {{(DATA_W+1-THR_W){thr_q[THR_W-1]}}, thr_q};
    assign thr_lo    = thr_cmp - HYST_V;
    assign above_thr = (mm_cmp > thr_cmp);
    assign above_lo  = (mm_cmp > thr_lo);
    assign frozen    = (state_q == TRIGGERED) || (state_q == HOLD);

    // Datapath: baseline tracker, subtractor, moving-mean delay line.
    always_comb begin
        thr_d    = thr_q;
        seeded_d = seeded_q;
        acc_d    = acc_q;
        d_r_d    = d_r_q;
        dl_d     = dl_q;
        wp_d     = wp_q;
        sum_d    = sum_q;
        if (enable) begin
            thr_d = threshold_value;
            if (!seeded_q) begin
                acc_d    = {x, {LPF_SHIFT{1'b0}}};
                seeded_d = 1'b1;
            end else if (!frozen) begin
                acc_d = acc_step;
            end
            d_r_d      = sat(x_ext - bl_ext);
            dl_d[wp_q] = d_r_q;
            wp_d       = wp_q + 1'b1;
            sum_d      = sum_q + {{WIN_LOG2{d_r_q[DATA_W-1]}}, d_r_q}
                               - {{WIN_LOG2{dl_q[wp_q][DATA_W-1]}}, dl_q[wp_q]};
        end
    end

    // Trigger FSM next-state and outputs.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        fill_d  = fill_q;
        trig_d  = 1'b0;
        cnt_d   = cnt_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_W'(WIN - 1)) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (above_thr) begin
                        state_d = TRIGGERED;
                        trig_d  = 1'b1;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                TRIGGERED: begin
                    if (!above_lo) begin
                        state_d = HOLD;
                        hcnt_d  = HOLD_V;
                    end
                end
                HOLD: begin
                    // A pulse still above threshold keeps restarting the dead time.
                    if (above_thr) begin
                        hcnt_d = HOLD_V;
                    end else if (hcnt_q <= HC_W'(1)) begin
                        hcnt_d  = '0;
                        state_d = ARMED;
                    end else begin
                        hcnt_d = hcnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        y = x;
        if (enable) begin
            case (output_selector)
                2'b00:   y = sat(dr_ext + bl_ext);
                2'b01:   y = sat(mm_ext + bl_ext);
                2'b10:   y = d_r_q;
                default: y = x;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thr_q    <= THR_W'(DEFAULT_THRESHOLD);
            seeded_q <= 1'b0;
            acc_q    <= '0;
            d_r_q    <= '0;
            for (int i = 0; i < WIN; i++) begin
                dl_q[i] <= '0;
            end
            wp_q     <= '0;
            sum_q    <= '0;
            fill_q   <= '0;
            state_q  <= IDLE;
            hcnt_q   <= '0;
            trig_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            thr_q    <= thr_d;
            seeded_q <= seeded_d;
            acc_q    <= acc_d;
            d_r_q    <= d_r_d;
            dl_q     <= dl_d;
            wp_q     <= wp_d;
            sum_q    <= sum_d;
            fill_q   <= fill_d;
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            trig_q   <= trig_d;
            cnt_q    <= cnt_d;
        end
    end

    assign trigger_output = trig_q & enable;
    assign triggered      = (state_q == TRIGGERED);
    assign trigger_count  = cnt_q;
    assign fsm_state      = state_q;

endmodule
